// File: rtl/program_loader.sv
// Loads a little-endian byte stream into memory as 32-bit words and holds the core in reset until the image is in place.
// Optional zero-fill of the whole memory before each load: define LOADER_CLEAR_EN.
module program_loader #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RESET_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic [7:0]            byte_data,
  input  logic                  byte_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int unsigned CW     = ADDR_WIDTH + 1;
  localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    HOLD,
    RUN
`ifdef LOADER_CLEAR_EN
    , CLEAR
`endif
  } state_t;

  state_t            state;
  logic [1:0]        bidx;
  logic [31:0]       wbuf;
  logic [HOLD_W-1:0] hold_cnt;

  logic [31:0] word_c;
  logic        hs_c;
  logic        ovf_c;

  // Current word with the incoming byte merged into its lane.
  always_comb begin
    word_c = wbuf;
    word_c[{bidx, 3'b000} +: 8] = byte_data;
    hs_c  = byte_valid && byte_ready && (state == LOAD);
    ovf_c = (word_count == CW'(MEM_WORDS));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      core_reset <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      bidx       <= '0;
      wbuf       <= '0;
      hold_cnt   <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (start) begin
            error      <= 1'b0;
            word_count <= '0;
            bidx       <= '0;
            wbuf       <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            core_reset <= 1'b1;
`ifdef LOADER_CLEAR_EN
            state     <= CLEAR;
            mem_we    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
`else
            state      <= LOAD;
            byte_ready <= 1'b1;
`endif
          end
        end
`ifdef LOADER_CLEAR_EN
        // Zero-fill walks mem_addr through the whole memory.
        CLEAR: begin
          if (mem_addr == ADDR_WIDTH'(MEM_WORDS - 1)) begin
            state      <= LOAD;
            byte_ready <= 1'b1;
          end else begin
            mem_we   <= 1'b1;
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
          end
        end
`endif
        LOAD: begin
          if (hs_c) begin
            if (bidx == 2'd3 || byte_last) begin
              bidx <= '0;
              wbuf <= '0;
              if (ovf_c) begin
                // Memory full: drop the word and keep draining until the last byte.
                error <= 1'b1;
                if (byte_last) begin
                  state      <= IDLE;
                  byte_ready <= 1'b0;
                  busy       <= 1'b0;
                end
              end else begin
                mem_we     <= 1'b1;
                mem_addr   <= word_count[ADDR_WIDTH-1:0];
                mem_wdata  <= word_c;
                word_count <= word_count + CW'(1);
                hold_cnt   <= '0;
                if (byte_last) begin
                  byte_ready <= 1'b0;
                  state      <= (bidx == 2'd3) ? HOLD : FLUSH;
                end
              end
            end else begin
              bidx <= bidx + 2'd1;
              wbuf <= word_c;
            end
          end
        end
        // hold_cnt counts edges since the final write, whether or not it was a flush.
        FLUSH, HOLD: begin
          if (hold_cnt == HOLD_W'(RESET_HOLD)) begin
            state      <= RUN;
            core_reset <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
          end else begin
            state    <= HOLD;
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: cycle-level reference model plus directed and random loads.
module tb_program_loader;

  localparam int MW = 4;
  localparam int AW = 2;
  localparam int H  = 5;
`ifdef LOADER_CLEAR_EN
  localparam int CLR = MW;
`else
  localparam int CLR = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic          byte_last = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready, mem_we, core_reset, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;

  program_loader #(.MEM_WORDS(MW), .ADDR_WIDTH(AW), .RESET_HOLD(H)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data), .byte_last(byte_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_reset(core_reset), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: tracks the load by byte count and cycle arithmetic.
  localparam int M_IDLE = 0, M_CLEAR = 1, M_LOAD = 2, M_REL = 3, M_RUN = 4;
  int          mode = M_IDLE;
  int          cyc = 0, clr_base = 0, fin_cyc = 0, nb = 0, pos = 0;
  int          e_addr = 0, e_wc = 0;
  logic [31:0] wacc = 32'h0, e_wdata = 32'h0;
  logic        e_we = 1'b0, e_ready = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0, e_creset = 1'b1;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mode = M_IDLE; e_we = 0; e_addr = 0; e_wdata = 0; e_ready = 0; e_busy = 0;
      e_done = 0; e_err = 0; e_wc = 0; e_creset = 1;
    end else begin
      cyc++;
      e_we = 0;
      if (start && (mode == M_IDLE || mode == M_RUN)) begin
        e_err = 0; e_wc = 0; nb = 0; wacc = 0; e_busy = 1; e_done = 0; e_creset = 1;
        if (CLR > 0) begin
          mode = M_CLEAR; clr_base = cyc; e_we = 1; e_addr = 0; e_wdata = 0; e_ready = 0;
        end else begin
          mode = M_LOAD; e_ready = 1;
        end
      end else if (mode == M_CLEAR) begin
        if (cyc - clr_base < MW) begin
          e_we = 1; e_addr = cyc - clr_base; e_wdata = 0;
        end else begin
          mode = M_LOAD; e_ready = 1;
        end
      end else if (mode == M_LOAD && byte_valid && e_ready) begin
        pos = nb % 4;
        nb++;
        wacc = wacc | (32'(byte_data) << (8 * pos));
        if (pos == 3 || byte_last) begin
          if (e_wc == MW) e_err = 1;
          else begin
            e_we = 1; e_addr = e_wc; e_wdata = wacc; e_wc++; fin_cyc = cyc;
          end
          wacc = 0;
          if (byte_last) begin
            e_ready = 0;
            if (e_we) mode = M_REL;
            else begin
              mode = M_IDLE; e_busy = 0;
            end
          end
        end
      end else if (mode == M_REL && cyc == fin_cyc + H + 1) begin
        mode = M_RUN; e_creset = 0; e_done = 1; e_busy = 0;
      end
    end
  end

  // Per-cycle compare plus a log of every write the DUT issues.
  logic        chk_en = 1'b0;
  logic        prev_cr = 1'b1;
  int          ncyc = 0, last_we_cyc = 0, fall_cyc = 0;
  int          wq_addr[$];
  logic [31:0] wq_data[$];

  initial forever begin
    @(negedge clk);
    ncyc++;
    if (chk_en) begin
      chk("mem_we", 64'(mem_we), 64'(e_we));
      if (e_we) begin
        chk("mem_addr", 64'(mem_addr), 64'(e_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
      end
      chk("byte_ready", 64'(byte_ready), 64'(e_ready));
      chk("core_reset", 64'(core_reset), 64'(e_creset));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("error", 64'(error), 64'(e_err));
      chk("word_count", 64'(word_count), 64'(e_wc));
    end
    if (mem_we === 1'b1) begin
      wq_addr.push_back(int'(mem_addr));
      wq_data.push_back(mem_wdata);
      last_we_cyc = ncyc;
    end
    if (prev_cr === 1'b1 && core_reset === 1'b0) fall_cyc = ncyc;
    prev_cr = core_reset;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic gap, input logic spur);
    int n = 0;
    byte_valid = 1'b1; byte_data = d; byte_last = l;
    if (spur) start = 1'b1;
    while (byte_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready timeout", 64'(byte_ready), 64'(1));
    @(negedge clk);
    byte_valid = 1'b0; byte_last = 1'b0; start = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic settle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("settle", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  int base;
  int len;
  logic [7:0] img [5];

  initial begin
    img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'h00; img[3] = 8'h00; img[4] = 8'h93;
    #1 reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst core_reset", 64'(core_reset), 64'(1));
    chk("rst mem_we", 64'(mem_we), 64'(0));
    chk("rst byte_ready", 64'(byte_ready), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst error", 64'(error), 64'(0));
    chk("rst word_count", 64'(word_count), 64'(0));
    reset = 1'b0;
    chk_en = 1'b1;

    // Partial flush, back-to-back then gapped.
    for (int g = 0; g < 2; g++) begin
      fall_cyc = 0;
      base = wq_data.size();
      pulse_start();
      for (int i = 0; i < 5; i++) send(img[i], i == 4, g == 1, 1'b0);
      settle();
      chk("pf nwrites", 64'(wq_data.size() - base), 64'(CLR + 2));
      chk("pf addr0", 64'(wq_addr[base + CLR]), 64'(0));
      chk("pf data0", 64'(wq_data[base + CLR]), 64'h00000513);
      chk("pf addr1", 64'(wq_addr[base + CLR + 1]), 64'(1));
      chk("pf data1", 64'(wq_data[base + CLR + 1]), 64'h00000093);
      chk("pf word_count", 64'(word_count), 64'(2));
      chk("pf done", 64'(done), 64'(1));
      chk("pf release", 64'(fall_cyc - last_we_cyc), 64'(H + 1));
    end

    // Overflow: 20 bytes into a 4-word memory.
    base = wq_data.size();
    pulse_start();
    for (int i = 0; i < 20; i++) send(8'(i + 1), i == 19, 1'b0, 1'b0);
    settle();
    chk("ovf nwrites", 64'(wq_data.size() - base), 64'(CLR + 4));
    for (int i = 0; i < 4; i++) chk("ovf addr", 64'(wq_addr[base + CLR + i]), 64'(i));
    chk("ovf data0", 64'(wq_data[base + CLR]), 64'h04030201);
    chk("ovf error", 64'(error), 64'(1));
    chk("ovf word_count", 64'(word_count), 64'(4));
    chk("ovf done", 64'(done), 64'(0));
    chk("ovf core_reset", 64'(core_reset), 64'(1));

    // Asynchronous reset in the middle of a load.
    pulse_start();
    for (int i = 0; i < 6; i++) send(8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("amid core_reset", 64'(core_reset), 64'(1));
    chk("amid mem_we", 64'(mem_we), 64'(0));
    chk("amid byte_ready", 64'(byte_ready), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = wq_data.size();
    pulse_start();
    send(8'hAA, 1'b0, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0, 1'b0);
    send(8'hCC, 1'b0, 1'b0, 1'b0);
    send(8'hDD, 1'b1, 1'b0, 1'b0);
    settle();
    chk("post addr0", 64'(wq_addr[base + CLR]), 64'(0));
    chk("post data0", 64'(wq_data[base + CLR]), 64'hDDCCBBAA);
    chk("post done", 64'(done), 64'(1));

    // Random images, random gaps and ignored mid-load starts.
    for (int it = 0; it < 30; it++) begin
      len = $urandom_range(1, 20);
      pulse_start();
      for (int i = 0; i < len; i++)
        send(8'($urandom), i == len - 1, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      settle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
